// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder behind the processor's RAM_ADDRESS / DATA_BUS_out /
//   DATA_BUS_in interface. It accepts one request at a time. Writes ack one
//   cycle after acceptance. Reads ack RD_LAT cycles after acceptance, with
//   registered data. It also stores image pixels and results for the
//   image-processing core.
//
// Parameters
//   DEPTH_LOG2 : log2 of the word count (array = 2**DEPTH_LOG2 x 16 bit)
//   RD_LAT     : read latency, acceptance edge to ack cycle, 1..4
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   mem_req       : request strobe, only honoured while idle
//   mem_we        : 1 = write, 0 = read (sampled with mem_req)
//   RAM_ADDRESS   : word address (sampled with mem_req)
//   DATA_BUS_out  : write data (sampled with mem_req)
//   DATA_BUS_in   : read data; holds until the next read ack
//   mem_ack       : one-cycle completion pulse
//   mem_err       : pulses with mem_ack for an out-of-range access
//   busy          : high from the cycle after acceptance through the ack
//
// Optional build macro DMEM_HOST_PORT_EN adds a host preload port:
//   host_we, host_addr, host_wdata (in), host_ready (out). A host write
//   commits when host_we & host_ready. The processor always wins.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] RAM_ADDRESS,
    input  logic [15:0] DATA_BUS_out,
`ifdef DMEM_HOST_PORT_EN
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ready,
`endif
    output logic [15:0] DATA_BUS_in,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        busy
);

    localparam int       DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q;
    logic [15:0]             addr_q;
    logic                    we_q;
    logic                    err_q;

    logic [15:0]             mem [0:DEPTH-1];
    logic [15:0]             rd_q;
    logic                    zero_q;

    logic                    accept;
    logic                    req_oor;
    logic                    rd_load;
    logic                    rd_oor;
    logic [DEPTH_LOG2-1:0]   rd_idx;

    // Address bits above the array are the out-of-range test. A right shift
    // keeps this legal when DEPTH_LOG2 = 16, because nothing survives the shift.
    assign accept  = (state_q == IDLE) && mem_req;
    assign req_oor = (RAM_ADDRESS >> DEPTH_LOG2) != 16'h0000;

    // The read-data register loads on the edge that enters RESP for a read.
    // With RD_LAT = 1, that edge is the accepting edge, so the live address is
    // used. Otherwise the latched address is used.
    always_comb begin
        rd_load = 1'b0;
        rd_oor  = err_q;
        rd_idx  = addr_q[DEPTH_LOG2-1:0];
        if (state_q == IDLE) begin
            rd_load = accept && !mem_we && (RD_LAT == 1);
            rd_oor  = req_oor;
            rd_idx  = RAM_ADDRESS[DEPTH_LOG2-1:0];
        end else if (state_q == RD_WAIT) begin
            rd_load = (cnt_q <= 3'd1);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    if (mem_we || (RD_LAT == 1)) state_d = RESP;
                    else                         state_d = RD_WAIT;
                end
            end
            // <= also guards against a counter that somehow reads zero.
            RD_WAIT: if (cnt_q <= 3'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = (state_q != IDLE);
        mem_ack     = (state_q == RESP);
        mem_err     = (state_q == RESP) && err_q;
        DATA_BUS_in = zero_q ? 16'h0000 : rd_q;
`ifdef DMEM_HOST_PORT_EN
        host_ready  = (state_q == IDLE) && !mem_req;
`endif
    end

    // ---------------- request latch and latency counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 3'd0;
            addr_q <= 16'h0000;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            addr_q <= RAM_ADDRESS;
            we_q   <= mem_we;
            err_q  <= req_oor;
            if (!mem_we && (RD_LAT > 1)) cnt_q <= LAT_LOAD;
        end else if (state_q == RD_WAIT && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // zero_q forces DATA_BUS_in to zero after reset and after an
    // out-of-range read. This keeps the array output register free of reset,
    // so the array can map onto a plain synchronous RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       zero_q <= 1'b1;
        else if (rd_load) zero_q <= rd_oor;
    end

    // ---------------- single-port array ----------------
    // At most one access happens per edge. A processor write occurs only on
    // an accepting edge. A read occurs on an accepting edge (RD_LAT = 1) or
    // in RD_WAIT. A host write needs mem_req low while idle.
`ifdef DMEM_HOST_PORT_EN
    logic host_commit;
    assign host_commit = host_we && (state_q == IDLE) && !mem_req &&
                         ((host_addr >> DEPTH_LOG2) == 16'h0000);
`endif

    always_ff @(posedge clk) begin
        if (accept && mem_we && !req_oor)
            mem[RAM_ADDRESS[DEPTH_LOG2-1:0]] <= DATA_BUS_out;
`ifdef DMEM_HOST_PORT_EN
        else if (host_commit)
            mem[host_addr[DEPTH_LOG2-1:0]] <= host_wdata;
`endif
        if (rd_load && !rd_oor)
            rd_q <= mem[rd_idx];
    end

    // A write ack holds DATA_BUS_in unchanged. we_q is kept for visibility
    // and possible future use.
    logic unused_ok;
    assign unused_ok = we_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. It uses three instances with RD_LAT 2, 1
// and 4. Each request pushes its expected response (data, err, latency) to a
// scoreboard queue. A negedge monitor pops and compares on every mem_ack.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_v  [3];
    logic        we_v   [3];
    logic [15:0] addr_v [3];
    logic [15:0] wd_v   [3];
    logic [15:0] rd_v   [3];
    logic        ack_v  [3];
    logic        err_v  [3];
    logic        busy_v [3];
`ifdef DMEM_HOST_PORT_EN
    logic        hwe_v  [3];
    logic [15:0] haddr_v[3];
    logic [15:0] hwd_v  [3];
    logic        hrdy_v [3];
`endif

    dmem_responder #(.DEPTH_LOG2(12), .RD_LAT(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .mem_req(req_v[0]), .mem_we(we_v[0]),
        .RAM_ADDRESS(addr_v[0]), .DATA_BUS_out(wd_v[0]),
`ifdef DMEM_HOST_PORT_EN
        .host_we(hwe_v[0]), .host_addr(haddr_v[0]), .host_wdata(hwd_v[0]), .host_ready(hrdy_v[0]),
`endif
        .DATA_BUS_in(rd_v[0]), .mem_ack(ack_v[0]), .mem_err(err_v[0]), .busy(busy_v[0]));

    dmem_responder #(.DEPTH_LOG2(12), .RD_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .mem_req(req_v[1]), .mem_we(we_v[1]),
        .RAM_ADDRESS(addr_v[1]), .DATA_BUS_out(wd_v[1]),
`ifdef DMEM_HOST_PORT_EN
        .host_we(hwe_v[1]), .host_addr(haddr_v[1]), .host_wdata(hwd_v[1]), .host_ready(hrdy_v[1]),
`endif
        .DATA_BUS_in(rd_v[1]), .mem_ack(ack_v[1]), .mem_err(err_v[1]), .busy(busy_v[1]));

    dmem_responder #(.DEPTH_LOG2(12), .RD_LAT(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .mem_req(req_v[2]), .mem_we(we_v[2]),
        .RAM_ADDRESS(addr_v[2]), .DATA_BUS_out(wd_v[2]),
`ifdef DMEM_HOST_PORT_EN
        .host_we(hwe_v[2]), .host_addr(haddr_v[2]), .host_wdata(hwd_v[2]), .host_ready(hrdy_v[2]),
`endif
        .DATA_BUS_in(rd_v[2]), .mem_ack(ack_v[2]), .mem_err(err_v[2]), .busy(busy_v[2]));

    typedef struct {
        int          k;
        logic [15:0] d;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          ack_cnt[3];
    logic [15:0] last_rd[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    // Scoreboard monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && ack_v[k]) begin
                ack_cnt[k] = ack_cnt[k] + 1;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_ack dut=%0d observed=1 expected=0", k);
                end
                if (sb.size() != 0) begin
                    exp_t x;
                    x = sb.pop_front();
                    check("ack_dut",  32'(k),       32'(x.k));
                    check("ack_data", {16'h0, rd_v[k]}, {16'h0, x.d});
                    check("ack_err",  {31'h0, err_v[k]}, {31'h0, x.e});
                    check("ack_lat",  32'(cyc - x.acc), 32'(x.lat));
                end
            end
        end
    end

    task automatic push(input int k, input logic we, input logic [15:0] rd_exp, input logic e, input int acc);
        exp_t x;
        if (!we) last_rd[k] = rd_exp;
        x.k = k; x.d = last_rd[k]; x.e = e; x.acc = acc;
        x.lat = we ? 1 : lat_of(k);
        sb.push_back(x);
    endtask

    task automatic wait_idle(input int k);
        int g;
        g = 0;
        while (busy_v[k] && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", {31'h0, busy_v[k]}, 32'h0);
    endtask

    // One complete request: drive, then measure busy width and confirm the ack was seen.
    task automatic run(input int k, input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] rd_exp, input logic e);
        int bcnt;
        @(negedge clk);
        wait_idle(k);
        req_v[k] = 1'b1; we_v[k] = we; addr_v[k] = a; wd_v[k] = wd;
        push(k, we, rd_exp, e, cyc);
        @(negedge clk);
        req_v[k] = 1'b0;
        bcnt = 0;
        while (busy_v[k] && bcnt < 50) begin
            bcnt++;
            @(negedge clk);
        end
        check("busy_width", 32'(bcnt), 32'(we ? 1 : lat_of(k)));
        check("sb_drained", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int a0;
        int quiet;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_v[k] = 0; we_v[k] = 0; addr_v[k] = 0; wd_v[k] = 0;
            ack_cnt[k] = 0; last_rd[k] = 16'h0000;
`ifdef DMEM_HOST_PORT_EN
            hwe_v[k] = 0; haddr_v[k] = 0; hwd_v[k] = 0;
`endif
        end
        repeat (3) @(negedge clk);
        check("rst_data", {16'h0, rd_v[0]}, 32'h0);
        check("rst_ack",  {31'h0, ack_v[0]}, 32'h0);
        check("rst_err",  {31'h0, err_v[0]}, 32'h0);
        check("rst_busy", {31'h0, busy_v[0]}, 32'h0);
        rst_n = 1'b1;

        // write then read, RD_LAT = 2
        run(0, 1'b1, 16'h0010, 16'hA5C3, 16'h0, 1'b0);
        run(0, 1'b0, 16'h0010, 16'h0,    16'hA5C3, 1'b0);

        // out-of-range: 0x1000 aliases index 0 if the range test were missing
        run(0, 1'b1, 16'h0000, 16'h5555, 16'h0, 1'b0);
        run(0, 1'b1, 16'h1000, 16'h1234, 16'h0, 1'b1);
        run(0, 1'b0, 16'h1000, 16'h0,    16'h0000, 1'b1);
        run(0, 1'b0, 16'h0000, 16'h0,    16'h5555, 1'b0);
        run(0, 1'b0, 16'hFFFF, 16'h0,    16'h0000, 1'b1);

        // hold mem_req for 6 edges: accepted at +0 and +3 only
        run(0, 1'b1, 16'h0001, 16'h0101, 16'h0, 1'b0);
        @(negedge clk);
        a0 = ack_cnt[0];
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'h0001;
        push(0, 1'b0, 16'h0101, 1'b0, cyc);
        push(0, 1'b0, 16'h0101, 1'b0, cyc + 3);
        repeat (6) @(negedge clk);
        req_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_acks", 32'(ack_cnt[0] - a0), 32'd2);
        check("hold_sb",   32'(sb.size()), 32'h0);

        // reset while in RD_WAIT: no ack ever appears for the discarded read
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'h0010;
        @(negedge clk);
        req_v[0] = 1'b0;
        check("pre_rst_busy", {31'h0, busy_v[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy_v[0]}, 32'h0);
        check("mid_rst_data", {16'h0, rd_v[0]}, 32'h0);
        check("mid_rst_ack",  {31'h0, ack_v[0]}, 32'h0);
        last_rd[0] = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        a0 = ack_cnt[0];
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_v[0]) quiet++;
        end
        check("post_rst_quiet", 32'(quiet + ack_cnt[0] - a0), 32'h0);
        run(0, 1'b0, 16'h0010, 16'h0, 16'hA5C3, 1'b0);

        // latency sweep: RD_LAT 1 and 4, write ack keeps DATA_BUS_in
        for (int k = 1; k < 3; k++) begin
            run(k, 1'b1, 16'h0010, 16'hA5C3, 16'h0, 1'b0);
            run(k, 1'b0, 16'h0010, 16'h0,    16'hA5C3, 1'b0);
            run(k, 1'b1, 16'h0022, 16'h7777, 16'h0, 1'b0);
            check("hold_after_wr", {16'h0, rd_v[k]}, 32'h0000A5C3);
            run(k, 1'b0, 16'h0022, 16'h0,    16'h7777, 1'b0);
        end

`ifdef DMEM_HOST_PORT_EN
        // host preload while idle
        @(negedge clk);
        hwe_v[0] = 1'b1; haddr_v[0] = 16'h0020; hwd_v[0] = 16'hBEEF;
        #1;
        check("host_ready_idle", {31'h0, hrdy_v[0]}, 32'h1);
        @(negedge clk);
        hwe_v[0] = 1'b0;
        run(0, 1'b0, 16'h0020, 16'h0, 16'hBEEF, 1'b0);
        // collision: the processor wins, and the host write lands only on retry
        run(0, 1'b1, 16'h0030, 16'h1111, 16'h0, 1'b0);
        @(negedge clk);
        hwe_v[0] = 1'b1; haddr_v[0] = 16'h0030; hwd_v[0] = 16'hCAFE;
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'h0030;
        push(0, 1'b0, 16'h1111, 1'b0, cyc);
        #1;
        check("host_ready_coll", {31'h0, hrdy_v[0]}, 32'h0);
        @(negedge clk);
        req_v[0] = 1'b0;
        wait_idle(0);
        @(negedge clk);
        hwe_v[0] = 1'b0;
        run(0, 1'b0, 16'h0030, 16'h0, 16'hCAFE, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("final_sb", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
